// File: rtl/nios2_mul_sequencer.sv
// rtl/nios2_mul_sequencer.sv - Nios II MUL/MULX sequencer built on one 16x16 multiplier
// Four partial products are issued in sequence and summed into a 64-bit accumulator, then corrected for signed operands.
module nios2_mul_sequencer #(
  parameter int EARLY_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACC, DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;

  state_t      state, next_state;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic [63:0] acc;
  logic [1:0]  step;
  logic [1:0]  prod_step;
  logic [31:0] prod;

  logic [15:0] a_half, b_half;
  logic [31:0] mult;
  logic [63:0] prod_ext, shifted;
  logic [63:0] corr_a, corr_b, final_sum;
  logic [1:0]  last_step;

  assign req_ready = (state == IDLE) && !flush && reset_n;
  assign busy      = (state != IDLE);

  // step bit 1 selects the high half of src1, bit 0 the high half of src2
  assign a_half    = step[1] ? src1[31:16] : src1[15:0];
  assign b_half    = step[0] ? src2[31:16] : src2[15:0];
  assign mult      = {16'b0, a_half} * {16'b0, b_half};

  assign prod_ext  = {32'b0, prod};
  assign shifted   = (prod_step == 2'd0) ? prod_ext :
                     (prod_step == 2'd3) ? (prod_ext << 32) : (prod_ext << 16);

  assign last_step = (op == OP_MUL && EARLY_LOW != 0) ? 2'd2 : 2'd3;

  assign corr_a    = ((op == OP_MULXSS || op == OP_MULXSU) && src1[31]) ? {src2, 32'b0} : 64'b0;
  assign corr_b    = ((op == OP_MULXSS) && src2[31]) ? {src1, 32'b0} : 64'b0;
  assign final_sum = acc + shifted - corr_a - corr_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid && req_ready) next_state = ISSUE;
      ISSUE:   if (step == last_step) next_state = ACC;
      ACC:     next_state = DONE;
      DONE:    if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op         <= 2'b0;
      src1       <= 32'b0;
      src2       <= 32'b0;
      acc        <= 64'b0;
      step       <= 2'b0;
      prod_step  <= 2'b0;
      prod       <= 32'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'b0;
    end else begin
      // the response is presented one cycle after the result register settles
      rsp_valid <= (state == DONE) && !flush && !(rsp_valid && rsp_ready);
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op   <= req_op;
            src1 <= req_src1;
            src2 <= req_src2;
            acc  <= 64'b0;
            step <= 2'b0;
          end
        end
        ISSUE: begin
          prod      <= mult;
          prod_step <= step;
          step      <= step + 2'd1;
          if (step != 2'd0) acc <= acc + shifted;
        end
        ACC: begin
          acc <= final_sum;
          if (!flush) rsp_result <= (op == OP_MUL) ? final_sum[31:0] : final_sum[63:32];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// tb/tb_nios2_mul_sequencer.sv - directed scoreboard bench for nios2_mul_sequencer
module tb_nios2_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  nios2_mul_sequencer #(.EARLY_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for rsp_valid within a bounded window, score latency and result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    logic [31:0] want;
    req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    want = sb.pop_front();
    check({tag, "_res"}, rsp_result, want);
  endtask

  task automatic after_handshake(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    check({tag, "_vld0"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rdy1"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_hold"}, rsp_result, exp);
  endtask

  task automatic no_rsp(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    check({tag, "_norsp"}, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b0; req_src1 = 32'b0; req_src2 = 32'b0;
    flush = 1'b0; rsp_ready = 1'b1;
    #12;
    check("rst_vld",   {31'b0, rsp_valid}, 32'd0);
    check("rst_res",   rsp_result, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_rdy",   {31'b0, req_ready}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rdy",   {31'b0, req_ready}, 32'd1);

    do_op("mul_a",    2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5);
    after_handshake("mul_a", 32'h000B_000F);
    do_op("mulxuu",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
    after_handshake("mulxuu", 32'hFFFF_FFFE);
    do_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5);
    after_handshake("mul_ff", 32'h0000_0001);
    do_op("mulxss_a", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 6);
    after_handshake("mulxss_a", 32'hFFFF_FFFF);
    do_op("mulxsu",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6);
    after_handshake("mulxsu", 32'hFFFF_FFFF);
    do_op("mulxss_b", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6);
    after_handshake("mulxss_b", 32'h4000_0000);

    // consumer stalls in DONE while a competing request is offered
    rsp_ready = 1'b0;
    do_op("hold", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 5);
    held = rsp_result;
    req_op = 2'b11; req_src1 = 32'h0000_0007; req_src2 = 32'h0000_0009; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_vld", {31'b0, rsp_valid}, 32'd1);
      check("hold_res", rsp_result, held);
      check("hold_rdy", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_busy", {31'b0, busy}, 32'd0);
    check("rel_vld",  {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("ign_busy", {31'b0, busy}, 32'd0);

    // flush at ISSUE step 1
    req_op = 2'b00; req_src1 = 32'd5; req_src2 = 32'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    check("fl_rdy", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_busy", {31'b0, busy}, 32'd0);
    no_rsp("fl", 8);

    // asynchronous reset during ISSUE
    req_op = 2'b11; req_src1 = 32'd5; req_src2 = 32'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_res",  rsp_result, 32'd0);
    check("mrst_vld",  {31'b0, rsp_valid}, 32'd0);
    #1;
    reset_n = 1'b1;
    no_rsp("mrst", 8);

    do_op("mul_3x4", 2'b00, 32'd3, 32'd4, 32'h0000_000C, 5);
    after_handshake("mul_3x4", 32'h0000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nios2_mul_sequencer.md
NIOS2_MUL_SEQUENCER -- requirements
Module: nios2_mul_sequencer

Interface
REQ-001 Parameter EARLY_LOW, default 1: when 1, MUL ops skip the hi*hi partial product (3 issues); when 0, all ops issue 4.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  2  00 MUL (low 32), 01 MULXSS, 10 MULXSU, 11 MULXUU (high 32).
REQ-007 req_src1, req_src2  in  32 each  operands; MULXSU treats src1 as signed, src2 as unsigned.
REQ-008 flush  in  1  synchronous abort of any in-flight op.
REQ-009 rsp_valid  out  1  result present.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_result  out  32  selected 32 bits of the 64-bit product.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 Datapath SHALL be one internal unsigned 16x16 multiplier with one product register, enabled only in ISSUE; product register is cleared by reset.
REQ-014 States SHALL be IDLE, ISSUE, ACC, DONE; req_ready = (state==IDLE) & ~flush.
REQ-015 Accept on req_valid & req_ready: latch op and operands, clear 64-bit accumulator and step counter, go to ISSUE.
REQ-016 ISSUE step k SHALL present aL*bL, aL*bH, aH*bL, aH*bH for k=0..3 in that order; leave ISSUE after step N-1 (N=3 for MUL with EARLY_LOW=1, else 4).
REQ-017 Each product SHALL be added to the accumulator the cycle after its issue, shifted left by 0, 16, 16, 32 bits respectively; accumulator arithmetic is 64-bit modulo 2^64.
REQ-018 ACC SHALL last one cycle, add the final product, apply signed correction, and register rsp_result; then DONE.
REQ-019 Signed correction for high ops: subtract (src1<0 ? src2 : 0)<<32 for MULXSS/MULXSU and (src2<0 ? src1 : 0)<<32 for MULXSS only; MUL needs none.
REQ-020 rsp_result = product[31:0] for MUL, product[63:32] otherwise.
REQ-021 rsp_valid SHALL rise N+2 rising edges after the accepting edge (MUL 5 with EARLY_LOW=1, otherwise 6).
REQ-022 In DONE, rsp_valid and rsp_result SHALL hold stable until rsp_ready; on rsp_valid & rsp_ready return to IDLE; next accept is earliest the following cycle.
REQ-023 rsp_result SHALL hold its last value outside DONE; it changes only in ACC.
REQ-024 flush in any state SHALL return to IDLE next edge, drop rsp_valid, and accept no request that cycle; flush coinciding with rsp handshake counts as flush (no effect on consumer, which already took data).
REQ-025 req_valid while not ready SHALL be ignored; operands are sampled only at acceptance.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, rsp_valid=0, rsp_result=0, busy=0, accumulator, counter, product register and latched op cleared; req_ready=1 once reset_n is high and flush low.
REQ-027 Reset mid-operation SHALL abort it with no response produced after release.

Verification
REQ-028 MUL 0x00010003 * 0x00020005, EARLY_LOW=1, rsp_ready=1 -> rsp_valid at edge 5, rsp_result 0x000B000F.
REQ-029 MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> rsp_result 0xFFFFFFFE at edge 6; MUL same operands -> 0x00000001.
REQ-030 MULXSS 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF; MULXSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF; MULXSS 0x80000000 * 0x80000000 -> 0x40000000.
REQ-031 rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_result stable, req_ready 0, new req_valid ignored; release -> IDLE next edge.
REQ-032 flush at ISSUE step 1, then reset_n pulse during a later ISSUE -> no rsp_valid either time; next MUL 3*4 returns 0x0000000C with normal latency.
